// File: rtl/cm_age_sched.sv
// cm_age_sched: age-based scheduler sharing one multi-cycle resource
// between RCNT requesters. The oldest waiting requester (lowest index on a
// tie) receives an exclusive grant, which is held until i_done or timeout.
//
// Ports:
//   i_clk      clock, rising edge
//   i_rst      asynchronous active-low reset
//   i_req      per-requester request level
//   i_done     resource finished, releases the current grant
//   o_gnt      one-hot grant, zero when no grant is held
//   o_gnt_vld  a grant is held
//   o_gnt_idx  binary index of the granted requester (holds when idle)
//   o_timeout  one-cycle pulse after a timeout release
//
// state | meaning
// IDLE  | no grant held; arbitrate among active requesters
// BUSY  | grant held by o_gnt_idx until i_done or timeout
module cm_age_sched #(
  parameter int RCNT      = 4,
  parameter int AGE_WIDTH = 8,
  parameter int TIMEOUT   = 64,
  localparam int IDX_WIDTH = (RCNT > 1) ? $clog2(RCNT) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [RCNT-1:0]      i_req,
  input  logic                 i_done,
  output logic [RCNT-1:0]      o_gnt,
  output logic                 o_gnt_vld,
  output logic [IDX_WIDTH-1:0] o_gnt_idx,
  output logic                 o_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [AGE_WIDTH-1:0] AGE_MAX = '1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]           state;
  logic [TW-1:0]        tmo_cnt;
  logic [AGE_WIDTH-1:0] age [RCNT];

  logic                 win_any;
  logic [IDX_WIDTH-1:0] win_idx;
  logic [AGE_WIDTH-1:0] win_age;

  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    win_age = '0;
    for (int i = 0; i < RCNT; i++) begin
      if (i_req[i] && (!win_any || age[i] > win_age)) begin
        win_any = 1'b1;
        win_idx = IDX_WIDTH'(i);
        win_age = age[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < RCNT; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < RCNT; i++) begin
        if (!i_req[i]) begin
          age[i] <= '0;
        end else if (state == IDLE && win_idx == IDX_WIDTH'(i)) begin
          age[i] <= '0;
        end else if (state == BUSY && o_gnt_idx == IDX_WIDTH'(i)) begin
          age[i] <= '0;
        end else if (age[i] != AGE_MAX) begin
          age[i] <= age[i] + AGE_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      o_gnt     <= '0;
      o_gnt_vld <= 1'b0;
      o_gnt_idx <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            state     <= BUSY;
            o_gnt_idx <= win_idx;
            o_gnt     <= {{(RCNT-1){1'b0}}, 1'b1} << win_idx;
            o_gnt_vld <= 1'b1;
            tmo_cnt   <= '0;
          end
        end
        BUSY: begin
          if (i_done) begin
            state     <= IDLE;
            o_gnt     <= '0;
            o_gnt_vld <= 1'b0;
          end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
            state     <= IDLE;
            o_gnt     <= '0;
            o_gnt_vld <= 1'b0;
            o_timeout <= 1'b1;
          end else if (TIMEOUT != 0) begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          o_gnt     <= '0;
          o_gnt_vld <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cm_age_sched.sv
// Testbench for cm_age_sched. Two instances share the stimulus:
// dut_a (AGE_WIDTH=2, no timeout) and dut_b (AGE_WIDTH=8, TIMEOUT=4).
// A behavioural model predicts each cycle's outputs into per-instance
// queues; a negedge monitor pops and compares.
module tb_cm_age_sched;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_req = 4'b0;
  logic       i_done = 1'b0;

  logic [3:0] a_gnt, b_gnt;
  logic       a_vld, b_vld;
  logic [1:0] a_idx, b_idx;
  logic       a_to, b_to;

  always #5 i_clk = ~i_clk;

  cm_age_sched #(.RCNT(4), .AGE_WIDTH(2), .TIMEOUT(0)) dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_done(i_done),
    .o_gnt(a_gnt), .o_gnt_vld(a_vld), .o_gnt_idx(a_idx), .o_timeout(a_to)
  );

  cm_age_sched #(.RCNT(4), .AGE_WIDTH(8), .TIMEOUT(4)) dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_done(i_done),
    .o_gnt(b_gnt), .o_gnt_vld(b_vld), .o_gnt_idx(b_idx), .o_timeout(b_to)
  );

  typedef struct {
    logic       vld;
    logic [3:0] gnt;
    int         idx;
    logic       to;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // model state, index 0 = dut_a, 1 = dut_b
  int m_age   [2][4];
  int m_owner [2];
  int m_held  [2];
  int m_last  [2];

  function automatic int age_max(int d);
    return (d == 0) ? 3 : 255;
  endfunction

  function automatic int tmo_of(int d);
    return (d == 0) ? 0 : 4;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) m_age[d][i] = 0;
      m_owner[d] = -1;
      m_held[d]  = 0;
      m_last[d]  = 0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step(input int d, input logic [3:0] r, input logic dn);
    exp_t e;
    int   w;
    int   nxt [4];
    logic [3:0] one;
    e.to = 1'b0;
    if (m_owner[d] < 0) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (r[i] && (w < 0 || m_age[d][i] > m_age[d][w])) w = i;
      for (int i = 0; i < 4; i++)
        nxt[i] = (!r[i] || i == w) ? 0 :
                 ((m_age[d][i] + 1 > age_max(d)) ? age_max(d) : m_age[d][i] + 1);
      if (w >= 0) begin
        m_owner[d] = w;
        m_held[d]  = 1;
        m_last[d]  = w;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        nxt[i] = (!r[i] || i == m_owner[d]) ? 0 :
                 ((m_age[d][i] + 1 > age_max(d)) ? age_max(d) : m_age[d][i] + 1);
      if (dn) begin
        m_owner[d] = -1;
      end else if (tmo_of(d) != 0 && m_held[d] == tmo_of(d)) begin
        m_owner[d] = -1;
        e.to = 1'b1;
      end else begin
        m_held[d] = m_held[d] + 1;
      end
    end
    for (int i = 0; i < 4; i++) m_age[d][i] = nxt[i];
    one = 4'b0001;
    e.vld = (m_owner[d] >= 0);
    e.gnt = (m_owner[d] >= 0) ? (one << m_owner[d]) : 4'b0000;
    e.idx = m_last[d];
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic cycle(input logic [3:0] r, input logic dn);
    i_req  = r;
    i_done = dn;
    @(posedge i_clk);
    model_step(0, r, dn);
    model_step(1, r, dn);
    cyc = cyc + 1;
    @(negedge i_clk);
  endtask

  task automatic check_out(input string nm, input exp_t e, input logic vld,
                           input logic [3:0] gnt, input logic [1:0] idx,
                           input logic to);
    checks = checks + 1;
    if (vld !== e.vld || gnt !== e.gnt || int'(idx) != e.idx || to !== e.to) begin
      errors = errors + 1;
      $display("FAIL %s cyc=%0d got vld=%b gnt=%b idx=%0d to=%b exp vld=%b gnt=%b idx=%0d to=%b",
               nm, cyc, vld, gnt, idx, to, e.vld, e.gnt, e.idx, e.to);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst) begin
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_out("dut_a", e, a_vld, a_gnt, a_idx, a_to);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_out("dut_b", e, b_vld, b_gnt, b_idx, b_to);
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b0;
    model_reset();
    i_req  = 4'b0;
    i_done = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
  endtask

  task automatic check_idle_now(input string nm);
    checks = checks + 1;
    if (a_gnt !== 4'b0 || a_vld !== 1'b0 || b_gnt !== 4'b0 || b_vld !== 1'b0 ||
        a_idx !== 2'd0 || b_idx !== 2'd0 || a_to !== 1'b0 || b_to !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL %s got a_gnt=%b a_vld=%b a_idx=%0d b_gnt=%b b_vld=%b b_idx=%0d exp all zero",
               nm, a_gnt, a_vld, a_idx, b_gnt, b_vld, b_idx);
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       dn;
    model_reset();
    do_reset();
    check_idle_now("reset_state");

    // single request, release by i_done in the 4th grant cycle
    repeat (4) cycle(4'b0000, 1'b0);
    repeat (4) cycle(4'b0100, 1'b0);
    cycle(4'b0100, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0);

    // equal ages, alternation between 1 and 3
    do_reset();
    for (int g = 0; g < 4; g++) begin
      repeat (3) cycle(4'b1010, 1'b0);
      cycle(4'b1010, 1'b1);
    end
    repeat (2) cycle(4'b0000, 1'b0);

    // age saturation while another requester owns the grant
    do_reset();
    cycle(4'b0010, 1'b0);
    repeat (10) cycle(4'b0011, 1'b0);
    repeat (2) cycle(4'b0111, 1'b0);
    cycle(4'b0111, 1'b1);
    repeat (4) cycle(4'b0111, 1'b0);
    cycle(4'b0000, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0);

    // timeout with requester dropping; grant held regardless
    do_reset();
    cycle(4'b0001, 1'b0);
    repeat (7) cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b1);
    repeat (3) cycle(4'b0000, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0);

    // asynchronous reset mid-grant
    cycle(4'b0001, 1'b0);
    repeat (2) cycle(4'b0001, 1'b0);
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    model_reset();
    #1;
    check_idle_now("async_rst");
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (6) cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b1);

    // random traffic
    r = 4'b0;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      if (n < 250) dn = ($urandom_range(0, 3) == 0);
      else         dn = ($urandom_range(0, 15) == 0);
      cycle(r, dn);
    end
    repeat (2) cycle(4'b0000, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
